// File: rtl/mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mac_seq_ctrl
// Purpose  : Sequencer and accumulator wrapped around an external 4x4
//            sequential shift-add multiplier. Operand pairs are accepted on a
//            valid/ready stream and each pair gets one mul_start pulse. The
//            operands are held on mul_a/mul_b while the multiply runs. The
//            8-bit product is sampled MUL_LAT cycles after the start pulse
//            and added into an accumulator. When the pair tagged last has
//            been added, the sum is presented on a valid/ready output.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   MUL_LAT   cycles from the mul_start cycle to the mul_op sample cycle (>= 2)
//   ACC_W     accumulator width in bits (>= 8)
// Ports
//   clk        in   1      system clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      controller can accept a pair (IDLE only)
//   in_a       in   4      multiplicand, unsigned
//   in_b       in   4      multiplier, unsigned
//   in_last    in   1      final pair of the current sum
//   mul_start  out  1      one-cycle start pulse to the multiplier
//   mul_a      out  4      multiplicand to the multiplier (held)
//   mul_b      out  4      multiplier to the multiplier (held)
//   mul_op     in   8      product from the multiplier
//   acc_valid  out  1      sum valid
//   acc_ready  in   1      downstream accepts the sum
//   acc_out    out  ACC_W  accumulated sum, unsigned
//   acc_ovf    out  1      sticky: the sum wrapped past 2^ACC_W - 1
//   busy       out  1      high in every state except IDLE
// ============================================================================
module mac_seq_ctrl #(
  parameter int MUL_LAT = 5,
  parameter int ACC_W   = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic             in_last,
  output logic             mul_start,
  output logic [3:0]       mul_a,
  output logic [3:0]       mul_b,
  input  logic [7:0]       mul_op,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_ovf,
  output logic             busy
);

  // The wait counter is loaded with MUL_LAT-2, which needs clog2(MUL_LAT-1)
  // bits; keep at least one bit so MUL_LAT=2 (load value 0) still elaborates.
  localparam int c_CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MUL_LAT - 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_ACC   = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [3:0]         r_a;
  logic [3:0]         r_b;
  logic               r_last;
  logic [c_CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf;

  logic               w_accept;
  logic [ACC_W:0]     w_sum;

  // A pair is only taken in IDLE; in_valid in any other state is ignored.
  assign w_accept = (r_state == S_IDLE) && in_valid;

  // One extra bit on the adder captures the carry out of the accumulator.
  assign w_sum = {1'b0, r_acc} + {{(ACC_W - 7){1'b0}}, mul_op};

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    mul_start = 1'b0;
    acc_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_next = S_START;
        end
      end
      S_START: begin
        mul_start = 1'b1;
        w_next    = S_WAIT;
      end
      S_WAIT: begin
        // START plus (MUL_LAT-1) WAIT cycles puts ACC exactly MUL_LAT
        // cycles after the start pulse.
        if (r_cnt == '0) begin
          w_next = S_ACC;
        end
      end
      S_ACC: begin
        w_next = r_last ? S_OUT : S_IDLE;
      end
      S_OUT: begin
        acc_valid = 1'b1;
        if (acc_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand hold registers: only an IDLE acceptance changes them, so the
  // multiplier sees stable operands from the start pulse to the sample cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= 4'd0;
      r_b    <= 4'd0;
      r_last <= 1'b0;
    end else if (w_accept) begin
      r_a    <= in_a;
      r_b    <= in_b;
      r_last <= in_last;
    end
  end

  // --------------------------------------------------------------------------
  // Latency down-counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == S_START) begin
      r_cnt <= c_CNT_LOAD;
    end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Accumulator and sticky overflow. mul_op is looked at only in ACC; the sum
  // and flag are cleared when the downstream consumes the result.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (r_state == S_ACC) begin
      r_acc <= w_sum[ACC_W-1:0];
      if (w_sum[ACC_W]) begin
        r_ovf <= 1'b1;
      end
    end else if ((r_state == S_OUT) && acc_ready) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end
  end

  assign mul_a   = r_a;
  assign mul_b   = r_b;
  assign acc_out = r_acc;
  assign acc_ovf = r_ovf;

endmodule
`default_nettype wire
